// File: rtl/rgbw_pkg.sv
// Shared widths, derived counter limit and channel indices for the RGBW PWM datapath.
package rgbw_pkg;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CH_NUM = 4;
  localparam int unsigned CH_W   = 2;

  // Last counter value of a period; the period is 2^CNT_W - 1 steps long.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 2);

  localparam logic [CH_W-1:0] CH_R     = CH_W'(0);
  localparam logic [CH_W-1:0] CH_G     = CH_W'(1);
  localparam logic [CH_W-1:0] CH_B     = CH_W'(2);
  localparam logic [CH_W-1:0] CH_W_IDX = CH_W'(3);
endpackage

// File: rtl/pwm_sequencer_if.sv
// Duty-write handshake bus between a register writer and the PWM sequencer.
interface pwm_sequencer_if;
  import rgbw_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_duty;

  modport master (output wr_valid, output wr_ch, output wr_duty, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_sequencer_channel.sv
// One PWM channel: shadow/active duty pair, pending flag and registered compare.
module pwm_channel
  import rgbw_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             commit_i,
  input  logic             bypass_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             pwm_o,
  output logic             pending_o
);
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;

  // While bypassed the active value tracks the shadow, including a same-cycle write.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (wr_en_i) begin
      shadow_d = duty_i;
      pend_d   = 1'b1;
    end
    if (bypass_i) begin
      active_d = shadow_d;
      pend_d   = 1'b0;
    end else if (commit_i && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    pwm_d = ~bypass_i & (active_q > cnt_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign pending_o = pend_q;
endmodule

// File: rtl/pwm_sequencer.sv
// RGBW PWM sequencer: prescaler step detect, shared period counter, commit-at-wrap duty update.
module pwm_sequencer
  import rgbw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              presc_in,
  input  logic              enable,
  pwm_sequencer_if.slave    wr,
  output logic [CH_NUM-1:0] pwm_out,
  output logic              period_start,
  output logic [CH_NUM-1:0] pending
);
  logic             presc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q;
  logic             start_q;
  logic             step;
  logic             commit;
  logic             wr_acc;

  assign step        = presc_in ^ presc_q;
  assign commit      = step & enable & (cnt_q == CNT_MAX);
  assign wr.wr_ready = ~commit;
  assign wr_acc      = wr.wr_valid & ~commit;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // period_start is delayed one extra cycle to line up with the first compare of the new period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= 1'b0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      presc_q <= presc_in;
      cnt_q   <= cnt_d;
      wrap_q  <= commit;
      start_q <= wrap_q;
    end
  end

  assign period_start = start_q;

  for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
    pwm_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_acc && (wr.wr_ch == CH_W'(i))),
      .duty_i    (wr.wr_duty),
      .commit_i  (commit),
      .bypass_i  (~enable),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_out[i]),
      .pending_o (pending[i])
    );
  end
endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
Controller for the RGBW PWM datapath. Consumes the toggling prescaler output of the clock divider and turns each toggle into one PWM step. Runs the shared period counter and holds a shadow and an active duty register per channel. Accepts duty writes over a valid/ready handshake and commits all pending writes together at the period boundary, so colour changes are glitch-free.

Parameters:
CH_NUM, 4, number of PWM channels (R, G, B, W)
CNT_W, 8, duty and counter width; period = 2^CNT_W - 1 steps
CH_W, 2, channel index width (clog2 of CH_NUM)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
presc_in  in  1  prescaler output, toggles at divided rate, synchronous to clk
enable  in  1  1 = run PWM; 0 = outputs low, counter parked
wr_valid  in  1  duty write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_ch  in  CH_W  target channel of write
wr_duty  in  CNT_W  new duty value
pwm_out  out  CH_NUM  PWM outputs, registered
period_start  out  1  one-cycle pulse when counter wraps to 0
pending  out  CH_NUM  per-channel shadow-not-yet-committed flags

Behaviour:
- Reset (reset=0, asynchronous): cnt=0, presc_q=0, every shadow and active duty=0, pending=0, pwm_out=0, period_start=0. Effective immediately; a reset mid-period discards all pending writes.
- step = presc_in XOR presc_q. presc_q registers presc_in every cycle, so each edge of presc_in gives exactly one step. Divider ratio N gives one step per N clk.
- MAX = 2^CNT_W - 2 (254 by default). On step & enable: cnt wraps MAX->0, else increments.
- commit = step & enable & (cnt == MAX). On commit, every channel with pending=1 copies shadow to active and clears pending. Channels with pending=0 keep their active value.
- enable=0: cnt forced to 0 and pwm_out forced to 0. Every cycle, active <= shadow for all channels and pending cleared. On re-enable, the first period uses the latest values.
- wr_ready = NOT commit (combinational). A write is never accepted in the commit cycle. The writer holds wr_valid; it is accepted the next cycle and is pending for the following period.
- Accepted write: shadow[wr_ch] <= wr_duty; pending[wr_ch] <= 1. Multiple writes to one channel in a period: last wins. wr_ch >= CH_NUM is accepted and ignored.
- Compare: pwm_out[i] <= enable & (active[i] > cnt), registered, so one cycle latency from a cnt change.
  - duty 0: output constantly low.
  - duty 255: constantly high, since cnt never reaches 255.
  - duty d: high for d of every 255 steps.
- period_start: registered, asserts for one clk in the cycle after the MAX->0 wrap. Aligned with the first pwm_out value of the new period.
- presc_in static while enable=1: counter and outputs hold their state; no timeout.

Decomposition:
- Shared package rgbw_pkg: CNT_W, CH_NUM, CH_W, derived CNT_MAX, and the channel index constants CH_R=0, CH_G=1, CH_B=2, CH_W_IDX=3.
- One natural sub-module, pwm_channel. It holds one shadow register, one active register and the pending flag, with inputs wr_en, duty, commit, bypass and cnt, and output pwm_out. Instantiate it CH_NUM times.
- The top level holds the step detector, the counter, the commit and ready logic, and the write decode.

Test Plan:
1. Reset, then enable=1 with presc_in toggling every 3 clk and no writes -> pwm_out=0000, period_start pulses every 765 clk, pending=0000.
2. Write R=128, G=0, B=255, W=1 with enable=0, then enable=1 -> in each period R is high for 128 steps (384 clk) and G is always low. B is always high. W is high for exactly 1 step.
3. Enabled with R active=10; write R=200 mid-period -> pending[0]=1 and R stays at 10 until the wrap. The period after period_start uses 200 and pending[0]=0.
4. Hold wr_valid with ch=1, duty=50 across the commit cycle -> wr_ready=0 in that cycle only. Accepted the next cycle; G changes one period later, not at that wrap.
5. Two writes to ch=2 (30 then 90) in one period -> after commit, active B=90. Write with wr_ch=3, duty=0 during the same period -> W is committed as 0 and ignored by no other channel.
6. Assert reset mid-period with pending=1111 -> outputs and pending go to 0 asynchronously. After release with enable=1, all outputs stay low.
